uart_tx_sched: RTL

UART transmit scheduler that pulls 16-bit words from the TX FIFO and serialises each as two UART frames, low byte first. It sits between the SPI control-register block, which supplies enable and baud divisor and fills the TX FIFO, and the `txd` pin. It also drives the 4-bit `state` value that the control-register block captures for STATE reads.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_sched_baud_gen.sv | 34 +++
 rtl/uart_tx_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX scheduler state encoding, width defaults,
// control-register address map and the parity helper.
package uart_pkg;

  localparam int UART_DATA_W = 16;
  localparam int UART_DIV_W  = 16;

  // TX scheduler state; encodings 7..15 are illegal and recover to idle.
  typedef enum logic [3:0] {
    TX_IDLE   = 4'd0,
    TX_FETCH  = 4'd1,
    TX_LOAD   = 4'd2,
    TX_START  = 4'd3,
    TX_DATA   = 4'd4,
    TX_PARITY = 4'd5,
    TX_STOP   = 4'd6
  } uart_tx_state_t;

  // Control-register map shared with the SPI control-register block.
  typedef enum logic [1:0] {
    UART_REG_CTRL   = 2'd0,
    UART_REG_BAUD   = 2'd1,
    UART_REG_TXDATA = 2'd2,
    UART_REG_STATE  = 2'd3
  } uart_reg_addr_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_sched_baud_gen.sv
// Bit-period generator: counts 0..div while run is high and pulses tick on
// the last clock of each bit period. clr restarts the period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = UART_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q;

  // Period counter: wraps to zero on the tick so periods run back to back.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == div) ? '0 : cnt_q + CNT_ONE;
    end
  end

  assign tick = run && (cnt_q == div);

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: pops 16-bit words from the TX FIFO and sends each
// as two 8N1 frames, low byte first, with no gap between the two frames.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DIV_W  = UART_DIV_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_en,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              txd,
  output logic              baud_tick,
  output logic              busy,
  output logic              frame_done,
  output logic [3:0]        state
);

  localparam int BYTE_W = 8;

  uart_tx_state_t    state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              byte_sel_q, byte_sel_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              txd_d;
  logic              baud_run, baud_clr;
  logic [BYTE_W-1:0] cur_byte;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (baud_clr),
    .run   (baud_run),
    .div   (div_q),
    .tick  (baud_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TX_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; unknown or disabled encodings fall back to idle.
  // NOTE: state_d gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = TX_IDLE;
    case (state_q)
      TX_IDLE:  state_d = (ctrl_en && !fifo_empty) ? TX_FETCH : TX_IDLE;
      TX_FETCH: state_d = TX_LOAD;
      TX_LOAD:  state_d = TX_START;
      TX_START: state_d = baud_tick ? TX_DATA : TX_START;
      TX_DATA: begin
        if (baud_tick && bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = TX_PARITY;
`else
          state_d = TX_STOP;
`endif
        end else begin
          state_d = TX_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: state_d = baud_tick ? TX_STOP : TX_PARITY;
`endif
      TX_STOP: begin
        if (baud_tick) state_d = byte_sel_q ? TX_IDLE : TX_START;
        else           state_d = TX_STOP;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Datapath next values: word/divisor capture, bit counter, byte select.
  always_comb begin
    word_d     = word_q;
    div_d      = div_q;
    byte_sel_d = byte_sel_q;
    bit_cnt_d  = bit_cnt_q;
    case (state_q)
      TX_LOAD: begin
        word_d     = fifo_rd_data;
        div_d      = baud_div;
        byte_sel_d = 1'b0;
        bit_cnt_d  = 3'd0;
      end
      TX_DATA: if (baud_tick) bit_cnt_d = bit_cnt_q + 3'd1;
      TX_STOP: if (baud_tick && !byte_sel_q) byte_sel_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      div_q      <= '0;
      byte_sel_q <= 1'b0;
      bit_cnt_q  <= 3'd0;
    end else begin
      word_q     <= word_d;
      div_q      <= div_d;
      byte_sel_q <= byte_sel_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  // Outputs: the serial level is computed for the state being entered so
  // txd can be a flop with no path from inputs; strobes decode current state.
  always_comb begin
    cur_byte = byte_sel_d ? word_d[2*BYTE_W-1:BYTE_W] : word_d[BYTE_W-1:0];
    txd_d    = 1'b1;
    case (state_d)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = cur_byte[bit_cnt_d];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: txd_d = even_parity(cur_byte);
`endif
      default:   txd_d = 1'b1;
    endcase

    baud_run = 1'b0;
    case (state_q)
      TX_START, TX_DATA, TX_STOP: baud_run = 1'b1;
`ifdef UART_TX_PARITY_EN
      TX_PARITY: baud_run = 1'b1;
`endif
      default: baud_run = 1'b0;
    endcase

    // Only the start bit after a fresh load needs an explicit restart; the
    // STOP->START hand-off already wraps the counter on the stop tick.
    baud_clr   = (state_q == TX_LOAD);
    fifo_rd_en = (state_q == TX_FETCH);
    frame_done = (state_q == TX_STOP) && baud_tick;
  end

  // Registered line and busy flag; reset forces the line idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd  <= 1'b1;
      busy <= 1'b0;
    end else begin
      txd  <= txd_d;
      busy <= (state_d != TX_IDLE);
    end
  end

  assign state = state_q;

endmodule
